// File: rtl/traffic_light_monitor.sv
// Traffic-light controller checker: decodes 7-segment countdown digits and LED phase
// on each 1 Hz tick and flags segment, countdown and phase-sequence errors.
`timescale 1ns/1ps
module traffic_light_monitor #(
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned MAX_COUNT      = 99
) (
    input  logic       CLK_50MHz,
    input  logic       Res,
    input  logic [4:0] LED,
    input  logic [6:0] Seg4,
    input  logic [6:0] Seg3,
    input  logic [6:0] Seg2,
    input  logic [6:0] Seg1,
    input  logic       Counter,
    input  logic       Clr_Err,
    output logic [1:0] Phase,
    output logic [7:0] Count_BCD,
    output logic [7:0] Cross_BCD,
    output logic       Valid,
    output logic       Seg_Err,
    output logic       Cnt_Err,
    output logic       Seq_Err,
    output logic [7:0] Err_Cnt
);

    localparam logic [7:0] MAX_C = 8'(MAX_COUNT);

    typedef enum logic {WAIT_FIRST, TRACK} state_t;

    state_t     state_q, state_d;
    logic       counter_q, armed_q, valid_q, base_ok_q;
    logic [1:0] phase_q, prev_led_q;
    logic [6:0] prev_cnt_q;
    logic [7:0] count_bcd_q, cross_bcd_q, err_cnt_q, err_cnt_d, err_base;
    logic       seg_err_q, cnt_err_q, seq_err_q;
    logic       seg_err_d, cnt_err_d, seq_err_d;
    logic       tick, seg_bad, led_ok, cnt_gt_max, seg_e, cnt_e, seq_e, any_e;
    logic [3:0] d4, d3, d2, d1;
    logic [6:0] cnt_val;
    logic [1:0] led_phase, adv_phase;

    function automatic logic [3:0] seg_decode(input logic [6:0] raw);
        logic [6:0] p;
        p = (SEG_ACTIVE_LOW != 0) ? ~raw : raw;
        case (p)
            7'h3F:   return 4'd0;
            7'h06:   return 4'd1;
            7'h5B:   return 4'd2;
            7'h4F:   return 4'd3;
            7'h66:   return 4'd4;
            7'h6D:   return 4'd5;
            7'h7D:   return 4'd6;
            7'h07:   return 4'd7;
            7'h7F:   return 4'd8;
            7'h6F:   return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    // armed_q blocks a tick when Counter was already high as reset released
    assign tick = Counter & ~counter_q & armed_q;

    always_comb begin
        d4 = seg_decode(Seg4);
        d3 = seg_decode(Seg3);
        d2 = seg_decode(Seg2);
        d1 = seg_decode(Seg1);
        seg_bad    = (d4 == 4'hF) | (d3 == 4'hF) | (d2 == 4'hF) | (d1 == 4'hF);
        cnt_val    = 7'({3'b000, d2} * 7'd10) + {3'b000, d1};
        cnt_gt_max = ({1'b0, cnt_val} > MAX_C);
        case (LED)
            5'b00100: led_phase = 2'd0;
            5'b01000: led_phase = 2'd1;
            5'b10000: led_phase = 2'd2;
            default:  led_phase = 2'd3;
        endcase
        led_ok    = (led_phase != 2'd3);
        adv_phase = (prev_led_q == 2'd2) ? 2'd0 : prev_led_q + 2'd1;
    end

    always_comb begin
        state_d = state_q;
        seg_e   = seg_bad;
        seq_e   = ~led_ok;
        cnt_e   = 1'b0;
        if (state_q == TRACK) begin
            if (!seg_bad && cnt_gt_max)
                cnt_e = 1'b1;
            // Countdown/transition rules only apply against a clean baseline
            if (base_ok_q && !seg_bad && led_ok) begin
                if (led_phase == prev_led_q) begin
                    if (prev_cnt_q == 7'd0)
                        seq_e = 1'b1;
                    else if (cnt_val != prev_cnt_q - 7'd1)
                        cnt_e = 1'b1;
                end else begin
                    if (prev_cnt_q != 7'd0 || led_phase != adv_phase)
                        seq_e = 1'b1;
                    if (cnt_val == 7'd0 || cnt_gt_max)
                        cnt_e = 1'b1;
                end
            end
        end
        if (tick)
            state_d = TRACK;
        any_e = seg_e | cnt_e | seq_e;

        seg_err_d = (seg_err_q & ~Clr_Err) | (tick & seg_e);
        cnt_err_d = (cnt_err_q & ~Clr_Err) | (tick & cnt_e);
        seq_err_d = (seq_err_q & ~Clr_Err) | (tick & seq_e);
        err_base  = Clr_Err ? '0 : err_cnt_q;
        err_cnt_d = err_base;
        if (tick && any_e && err_base != 8'hFF)
            err_cnt_d = err_base + 8'd1;
    end

    always_ff @(posedge CLK_50MHz) begin
        if (Res) begin
            state_q     <= WAIT_FIRST;
            counter_q   <= 1'b0;
            armed_q     <= ~Counter;
            valid_q     <= 1'b0;
            base_ok_q   <= 1'b0;
            phase_q     <= 2'd3;
            prev_led_q  <= 2'd3;
            prev_cnt_q  <= '0;
            count_bcd_q <= '0;
            cross_bcd_q <= '0;
            seg_err_q   <= 1'b0;
            cnt_err_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= Counter;
            armed_q   <= armed_q | ~Counter;
            valid_q   <= tick;
            seg_err_q <= seg_err_d;
            cnt_err_q <= cnt_err_d;
            seq_err_q <= seq_err_d;
            err_cnt_q <= err_cnt_d;
            if (tick) begin
                phase_q     <= led_phase;
                count_bcd_q <= {d2, d1};
                cross_bcd_q <= {d4, d3};
                prev_led_q  <= led_phase;
                prev_cnt_q  <= cnt_val;
                base_ok_q   <= led_ok & ~seg_bad;
            end
        end
    end

    assign Phase     = phase_q;
    assign Count_BCD = count_bcd_q;
    assign Cross_BCD = cross_bcd_q;
    assign Valid     = valid_q;
    assign Seg_Err   = seg_err_q;
    assign Cnt_Err   = cnt_err_q;
    assign Seq_Err   = seq_err_q;
    assign Err_Cnt   = err_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: a digit/phase-level reference model
// predicts each checked tick; a monitor compares whenever Valid pulses.
`timescale 1ns/1ps
module tb_traffic_light_monitor;

    localparam int unsigned TB_MAX = 50;

    logic       clk = 1'b0;
    logic       Res = 1'b1;
    logic [4:0] LED = '0;
    logic [6:0] Seg4 = '1, Seg3 = '1, Seg2 = '1, Seg1 = '1;
    logic       Counter = 1'b0;
    logic       Clr_Err = 1'b0;
    logic [1:0] Phase;
    logic [7:0] Count_BCD, Cross_BCD, Err_Cnt;
    logic       Valid, Seg_Err, Cnt_Err, Seq_Err;

    always #10 clk = ~clk;

    traffic_light_monitor #(.SEG_ACTIVE_LOW(1), .MAX_COUNT(TB_MAX)) dut (
        .CLK_50MHz(clk), .Res(Res), .LED(LED),
        .Seg4(Seg4), .Seg3(Seg3), .Seg2(Seg2), .Seg1(Seg1),
        .Counter(Counter), .Clr_Err(Clr_Err),
        .Phase(Phase), .Count_BCD(Count_BCD), .Cross_BCD(Cross_BCD),
        .Valid(Valid), .Seg_Err(Seg_Err), .Cnt_Err(Cnt_Err), .Seq_Err(Seq_Err),
        .Err_Cnt(Err_Cnt)
    );

    typedef struct {
        int phase;
        int cnt_bcd;
        int cross_bcd;
        int seg;
        int cnt;
        int seq;
        int errs;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // reference model state, in digit/phase terms
    bit   m_track, m_base_ok, m_seg, m_cnt, m_seq;
    int   m_base_li, m_base_cnt, m_errs;
    logic [6:0] dig_pat [10];

    function automatic logic [6:0] letters(input string s);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < s.len(); i++)
            p[int'(s[i]) - 97] = 1'b1;
        return p;
    endfunction

    // digit >=0 : that numeral; -2 : blank; -1 : random non-numeral pattern
    function automatic logic [6:0] encode(input int d);
        logic [6:0] p;
        bit hit;
        if (d >= 0) p = dig_pat[d];
        else if (d == -2) p = '0;
        else begin
            do begin
                p = 7'($urandom);
                hit = 1'b0;
                for (int k = 0; k < 10; k++)
                    if (p == dig_pat[k]) hit = 1'b1;
            end while (hit);
        end
        return ~p;
    endfunction

    function automatic int nib(input int d);
        return (d < 0) ? 15 : d;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_track = 0; m_base_ok = 0; m_seg = 0; m_cnt = 0; m_seq = 0;
        m_base_li = 3; m_base_cnt = 0; m_errs = 0;
        sb_q.delete();
    endtask

    task automatic model_tick(input logic [4:0] led, input int d4, input int d3,
                              input int d2, input int d1, input bit clr);
        exp_t e;
        int li, cnt;
        bit seg_bad, led_ok, se, ce, qe;
        if (led == 5'b00100) li = 0;
        else if (led == 5'b01000) li = 1;
        else if (led == 5'b10000) li = 2;
        else li = 3;
        led_ok  = (li != 3);
        seg_bad = (d4 < 0) || (d3 < 0) || (d2 < 0) || (d1 < 0);
        cnt = seg_bad ? 0 : d2 * 10 + d1;
        se = seg_bad; qe = !led_ok; ce = 0;
        if (m_track) begin
            if (!seg_bad && cnt > int'(TB_MAX)) ce = 1;
            if (m_base_ok && !seg_bad && led_ok) begin
                if (li == m_base_li) begin
                    if (m_base_cnt == 0) qe = 1;
                    else if (cnt != m_base_cnt - 1) ce = 1;
                end else begin
                    if (m_base_cnt != 0 || li != (m_base_li + 1) % 3) qe = 1;
                    if (cnt < 1 || cnt > int'(TB_MAX)) ce = 1;
                end
            end
        end
        m_track = 1; m_base_ok = led_ok && !seg_bad; m_base_li = li; m_base_cnt = cnt;
        if (clr) begin m_seg = 0; m_cnt = 0; m_seq = 0; m_errs = 0; end
        m_seg |= se; m_cnt |= ce; m_seq |= qe;
        if ((se || ce || qe) && m_errs < 255) m_errs++;
        e.phase = li; e.cnt_bcd = nib(d2) * 16 + nib(d1); e.cross_bcd = nib(d4) * 16 + nib(d3);
        e.seg = m_seg; e.cnt = m_cnt; e.seq = m_seq; e.errs = m_errs;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (Valid) begin
            if (sb_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_valid: got Valid=1 expected none at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("phase", int'(Phase), mon_e.phase);
                check("count_bcd", int'(Count_BCD), mon_e.cnt_bcd);
                check("cross_bcd", int'(Cross_BCD), mon_e.cross_bcd);
                check("seg_err", int'(Seg_Err), mon_e.seg);
                check("cnt_err", int'(Cnt_Err), mon_e.cnt);
                check("seq_err", int'(Seq_Err), mon_e.seq);
                check("err_cnt", int'(Err_Cnt), mon_e.errs);
            end
        end
    end

    task automatic do_tick(input logic [4:0] led, input int d4, input int d3,
                           input int d2, input int d1, input bit clr);
        @(negedge clk); Counter = 1'b0; Clr_Err = 1'b0;
        @(negedge clk);
        LED = led; Seg4 = encode(d4); Seg3 = encode(d3); Seg2 = encode(d2); Seg1 = encode(d1);
        Clr_Err = clr; Counter = 1'b1;
        model_tick(led, d4, d3, d2, d1, clr);
        @(negedge clk); Clr_Err = 1'b0;
        for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL valid_timeout: got no Valid expected one at %0t", $time);
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk); Res = 1'b1; Counter = 1'b0; Clr_Err = 1'b0;
        @(negedge clk);
        @(negedge clk); Res = 1'b0;
        model_reset();
    endtask

    task automatic check_idle(input string tag, input int errs);
        check({tag, "_seg"}, int'(Seg_Err), 0);
        check({tag, "_cnt"}, int'(Cnt_Err), 0);
        check({tag, "_seq"}, int'(Seq_Err), 0);
        check({tag, "_errcnt"}, int'(Err_Cnt), errs);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    localparam logic [4:0] GRN = 5'b00100, YEL = 5'b01000, RED = 5'b10000;

    initial begin
        int ph, cnt, r, d2, d1;
        logic [4:0] led;
        logic [4:0] phase_led [3];
        phase_led[0] = GRN; phase_led[1] = YEL; phase_led[2] = RED;
        dig_pat[0] = letters("abcdef");  dig_pat[1] = letters("bc");
        dig_pat[2] = letters("abdeg");   dig_pat[3] = letters("abcdg");
        dig_pat[4] = letters("bcfg");    dig_pat[5] = letters("acdfg");
        dig_pat[6] = letters("acdefg");  dig_pat[7] = letters("abc");
        dig_pat[8] = letters("abcdefg"); dig_pat[9] = letters("abcdfg");
        model_reset();

        do_reset();
        check("rst_phase", int'(Phase), 3);
        check("rst_count_bcd", int'(Count_BCD), 0);
        check("rst_cross_bcd", int'(Cross_BCD), 0);
        check("rst_valid", int'(Valid), 0);
        check_idle("rst", 0);

        do_tick(GRN, 2, 7, 1, 5, 0);
        do_tick(GRN, 2, 6, 1, 4, 0);
        do_tick(GRN, 2, 5, 1, 3, 0);

        do_reset();
        do_tick(GRN, 0, 0, 0, 5, 0);
        do_tick(GRN, 0, 0, 0, 3, 0);

        do_reset();
        do_tick(GRN, 0, 0, 0, 0, 0);
        do_tick(RED, 0, 0, 2, 0, 0);
        do_reset();
        do_tick(GRN, 0, 0, 0, 0, 0);
        do_tick(YEL, 0, 0, 2, 0, 0);
        do_tick(YEL, 0, 0, 1, 9, 0);
        do_tick(YEL, 0, 0, 1, 7, 0);
        do_tick(YEL, 0, 0, 5, 1, 0);

        do_tick(YEL, 0, 0, 1, -2, 0);
        do_tick(YEL, 3, -1, 0, 4, 0);

        // reset coincident with a tick, Counter still high as reset releases
        @(negedge clk); Counter = 1'b0;
        @(negedge clk); Counter = 1'b1; LED = GRN; Res = 1'b1;
        @(negedge clk); Res = 1'b0;
        model_reset();
        check("midchk_valid", int'(Valid), 0);
        check("midchk_phase", int'(Phase), 3);
        check_idle("midchk", 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_high_valid", int'(Valid), 0);
        end
        do_tick(RED, 1, 1, 1, 0, 0);

        do_reset();
        for (int i = 0; i < 260; i++) do_tick(5'b00000, 0, 0, 0, 9, 0);
        check("sat_errcnt", int'(Err_Cnt), 255);
        @(negedge clk); Clr_Err = 1'b1;
        @(negedge clk); Clr_Err = 1'b0;
        m_seg = 0; m_cnt = 0; m_seq = 0; m_errs = 0;
        check_idle("clr", 0);
        do_tick(GRN, 0, -1, 0, 5, 0);
        do_tick(5'b00011, 0, 0, 0, 4, 1);

        do_reset();
        ph = 0; cnt = $urandom_range(1, TB_MAX);
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 99);
            led = phase_led[ph]; d2 = cnt / 10; d1 = cnt % 10;
            if (r < 4) led = 5'($urandom);
            else if (r < 8) d1 = -1;
            else if (r < 12) begin d2 = $urandom_range(0, 9); d1 = $urandom_range(0, 9); end
            do_tick(led, $urandom_range(0, 9), $urandom_range(0, 9), d2, d1, r >= 97);
            for (int k = 0; k < ((r >= 12 && r < 15) ? 2 : 1); k++) begin
                if (cnt > 0) cnt--;
                else begin ph = (ph + 1) % 3; cnt = $urandom_range(1, TB_MAX); end
            end
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
